prio_enc_scanner: RTL
=====================

Name: prio_enc_scanner

Overview:
Parametrised, registered successor to the 16-bit combinational MSB priority encoder. It accepts a WIDTH-bit request vector over a valid/ready handshake. In SINGLE mode it returns the index of the highest set bit. In SCAN mode it returns the index of every set bit, one per output handshake, from MSB to LSB. It sits behind the tt_um wrapper, fed from ui_in/uio_in, and drives uo_out.

Parameters:
WIDTH, 16, request vector width (2..64)
OUT_W, 8, output index width; must be at least clog2(WIDTH)
NONE_CODE, 8'hF0, code emitted for an all-zero vector; truncated or zero-extended to OUT_W

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  reset, asynchronous assert, active-low
ena  input  1  enable; low freezes all state
in_valid  input  1  request vector valid
in_ready  output  1  block can accept a vector
in_vec  input  WIDTH  request vector
in_mode  input  1  0 = SINGLE, 1 = SCAN; sampled with in_vec
out_valid  output  1  out_idx is valid
out_ready  input  1  consumer accepts out_idx
out_idx  output  OUT_W  set-bit index, zero-extended; NONE_CODE when no bit is set
out_none  output  1  current result is NONE_CODE
out_last  output  1  final result for the current vector

Behaviour:
- Reset and async clear: rst_n low asynchronously forces state=IDLE, pend=0, mode_r=0, out_valid=0. Resulting outputs: out_idx=NONE_CODE, out_none=1, out_last=1 (all meaningless while out_valid=0).
- Reset mid-scan discards the remaining bits. No output appears after reset until a new vector is accepted.
- States: IDLE, BUSY.
- in_ready = ena & ((state==IDLE) | (out_valid & out_ready & out_last)). Back-to-back vectors are accepted with no bubble.
- Accept (in_valid & in_ready on an edge):
  - pend <= in_vec, mode_r <= in_mode, state <= BUSY.
  - out_valid is high the next cycle (latency 1).
- BUSY, combinational from pend and mode_r:
  - hi = index of the highest set bit in pend.
  - out_idx = hi, or NONE_CODE if pend==0.
  - out_none = (pend==0).
  - out_last = (mode_r==0) | (pend==0) | ((pend with bit hi cleared)==0).
- out_valid = ena & (state==BUSY).
- Output handshake (out_valid & out_ready):
  - If out_last: state <= IDLE, unless a new vector is accepted on the same edge, in which case it stays BUSY with the new pend.
  - Else: clear bit hi of pend and stay BUSY.
- Stall: with out_ready low, out_idx, out_none and out_last are held stable.
- All-zero vector: exactly one result: NONE_CODE, out_none=1, out_last=1, in either mode.
- SINGLE mode: exactly one result per vector, even if several bits are set.
- SCAN mode: number of results = popcount(in_vec), or 1 for an all-zero vector. Indices strictly decrease.
- ena low:
  - No register updates.
  - in_ready=0 and out_valid=0; handshakes are ignored.
  - Internal state is held; when ena returns high the same result reappears.
- Width rules:
  - Index computed in clog2(WIDTH) bits, then zero-extended to OUT_W.
  - Bit WIDTH-1 has highest priority.
- No combinational path from in_vec to out_idx. out_* depend only on registers, plus ena for out_valid.

Test Plan:
- SINGLE, in_vec=16'h2AF1, out_ready=1 -> one cycle after accept: out_idx=0x0D, out_last=1, out_none=0. Then back to IDLE.
- SINGLE, 16'h0001 -> out_idx=0x00, last=1. Next, 16'h0000 in either mode -> out_idx=0xF0, out_none=1, last=1.
- SCAN, 16'h8005, out_ready toggled 1,0,1,1 -> sequence 0x0F, 0x02 (held stable through the stall cycle), 0x00 with last=1 on 0x00 only.
- Back-to-back: SCAN 16'hC000 then SINGLE 16'hFFFF, in_valid held high -> outputs 0x0F, 0x0E(last), 0x0F(last). The second vector is accepted on the 0x0E handshake edge with no bubble.
- Reset mid-scan: SCAN 16'hFFFF, rst_n low after two results -> out_valid=0 immediately (async). After release: in_ready=1 and no stale output.
- ena low for 3 cycles during SCAN 16'hAAAA after result 0x0F -> out_valid=0 and in_ready=0 throughout. On re-enable, the result is 0x0D, then 0x0B, 0x09, 0x07, 0x05, 0x03, 0x01 (last).

Source files
------------

// File: rtl/prio_enc_scanner_if.sv
// Request/result handshake bundle for prio_enc_scanner.
// The master drives request vectors and consumes results; the slave is the scanner.
interface prio_enc_scanner_if #(
  parameter int WIDTH = 16,
  parameter int OUT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_vec;
  logic             in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_idx;
  logic             out_none;
  logic             out_last;

  modport master (
    output in_valid, in_vec, in_mode, out_ready,
    input  in_ready, out_valid, out_idx, out_none, out_last
  );

  modport slave (
    input  in_valid, in_vec, in_mode, out_ready,
    output in_ready, out_valid, out_idx, out_none, out_last
  );
endinterface

// File: rtl/prio_enc_scanner.sv
// Registered MSB priority encoder with an optional scan mode.
// SINGLE mode reports the highest set bit of each accepted vector.
// SCAN mode reports every set bit, MSB first, one per output handshake.
// An all-zero vector yields a single NONE_CODE result.
module prio_enc_scanner #(
  parameter int         WIDTH     = 16,
  parameter int         OUT_W     = 8,
  parameter logic [7:0] NONE_CODE = 8'hF0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ena,
  prio_enc_scanner_if.slave bus
);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [OUT_W-1:0] NONE_OUT = OUT_W'(NONE_CODE);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             mode_q, mode_d;

  logic [IW-1:0]    hi;
  logic [WIDTH-1:0] pend_clr;
  logic             none;
  logic             last;
  logic             in_fire;
  logic             out_fire;

  // Highest set bit of the pending vector; ascending scan lets the top bit win.
  always_comb begin
    hi = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (pend_q[i]) hi = IW'(i);
    end
    pend_clr     = pend_q;
    pend_clr[hi] = 1'b0;
    none         = (pend_q == '0);
    last         = !mode_q || none || (pend_clr == '0);
  end

  // Handshake outputs; results come only from registered state.
  always_comb begin
    bus.out_valid = ena && (state_q == BUSY);
    bus.in_ready  = ena && ((state_q == IDLE) || (bus.out_valid && bus.out_ready && last));
    bus.out_idx   = none ? NONE_OUT : OUT_W'(hi);
    bus.out_none  = none;
    bus.out_last  = last;
    in_fire       = bus.in_valid && bus.in_ready;
    out_fire      = bus.out_valid && bus.out_ready;
  end

  // Next state: a new accept overrides the retire of the final result on the same edge.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    mode_d  = mode_q;
    if (out_fire) begin
      if (last) state_d = IDLE;
      else      pend_d  = pend_clr;
    end
    if (in_fire) begin
      state_d = BUSY;
      pend_d  = bus.in_vec;
      mode_d  = bus.in_mode;
    end
  end

  // State registers; ena low freezes everything since neither handshake can fire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
      mode_q  <= 1'b0;
    end else if (ena) begin
      state_q <= state_d;
      pend_q  <= pend_d;
      mode_q  <= mode_d;
    end
  end
endmodule
